// File: rtl/bnn_pkg.sv
// Shared types and sizing constants for the BNN host-side stream loader.
package bnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        START,
        STREAM,
        WAIT_ANS,
        DONE,
        ERR
    } loader_state_t;

    localparam int unsigned PIXEL_BITS  = 784;
    localparam int unsigned W1_BITS     = 72;
    localparam int unsigned W2_BITS     = 288;
    localparam int unsigned W3_BITS     = 1960;
    localparam int unsigned WEIGHT_BITS = W1_BITS + W2_BITS + W3_BITS;
    localparam int unsigned ANS_W       = 4;
    localparam int unsigned ANS_TIMEOUT = 65535;

endpackage

// File: rtl/bnn_word_serializer.sv
// Two-deep word buffer (shift + holding register) that emits one bit per lane per cycle,
// MSB-first, and flags a byte-boundary reload that finds the holding register empty.
module bnn_word_serializer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_prime,
    input  logic        i_active,
    input  logic        i_shift_en,
    input  logic        i_words_left,
    input  logic [15:0] i_s_data,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    output logic        o_accept,
    output logic        o_primed,
    output logic        o_underrun,
    output logic        o_bit_w,
    output logic        o_bit_p
);

    logic [15:0] r_shift;
    logic [15:0] r_hold;
    logic        r_shift_loaded;
    logic        r_hold_full;
    logic [2:0]  r_bit_idx;
    logic        w_to_shift;
    logic        w_reload;

    always_comb begin
        o_s_ready  = i_active && !r_hold_full && i_words_left;
        o_accept   = i_s_valid && o_s_ready;
        // Only the very first word of a load bypasses the holding register.
        w_to_shift = i_prime && !r_shift_loaded;
        w_reload   = i_shift_en && (r_bit_idx == 3'd7);
        o_underrun = w_reload && !r_hold_full && i_words_left;
        o_primed   = r_shift_loaded && r_hold_full;
        o_bit_w    = r_shift[15];
        o_bit_p    = r_shift[7];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift        <= '0;
            r_hold         <= '0;
            r_shift_loaded <= 1'b0;
            r_hold_full    <= 1'b0;
            r_bit_idx      <= '0;
        end else if (i_clear) begin
            r_shift_loaded <= 1'b0;
            r_hold_full    <= 1'b0;
            r_bit_idx      <= '0;
        end else begin
            if (o_accept && w_to_shift) begin
                r_shift        <= i_s_data;
                r_shift_loaded <= 1'b1;
            end else if (i_shift_en) begin
                r_shift <= w_reload ? r_hold : {r_shift[14:0], 1'b0};
            end

            if (o_accept && !w_to_shift) begin
                r_hold      <= i_s_data;
                r_hold_full <= 1'b1;
            end else if (w_reload) begin
                r_hold_full <= 1'b0;
            end

            if (i_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/bnn_stream_loader.sv
// Host-side loader: prefetches two words, frames the serial pixel/weight load with mode,
// then waits for the classifier answer and holds it as a registered result.
module bnn_stream_loader #(
    parameter int unsigned PIXEL_BITS  = bnn_pkg::PIXEL_BITS,
    parameter int unsigned WEIGHT_BITS = bnn_pkg::WEIGHT_BITS,
    parameter int unsigned ANS_TIMEOUT = bnn_pkg::ANS_TIMEOUT
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [15:0]               i_s_data,
    input  logic                      i_s_valid,
    output logic                      o_s_ready,
    output logic                      o_mode,
    output logic                      o_d_in_p,
    output logic                      o_d_in_w,
    input  logic [bnn_pkg::ANS_W-1:0] i_ans_in,
    input  logic                      i_ans_valid,
    output logic [bnn_pkg::ANS_W-1:0] o_result,
    output logic                      o_result_valid,
    output logic                      o_busy,
    output logic                      o_err_underrun,
    output logic                      o_err_timeout
);
    import bnn_pkg::*;

    localparam int unsigned WORDS = (WEIGHT_BITS + 7) / 8;
    localparam int unsigned BCW   = $clog2(WEIGHT_BITS + 1);
    localparam int unsigned WCW   = $clog2(WORDS + 1);
    localparam int unsigned TCW   = $clog2(ANS_TIMEOUT + 1);

    localparam logic [BCW-1:0] PIX_LIM  = BCW'(PIXEL_BITS);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WEIGHT_BITS - 1);
    localparam logic [WCW-1:0] WORDS_L  = WCW'(WORDS);
    localparam logic [TCW-1:0] TO_LAST  = TCW'(ANS_TIMEOUT - 1);

    loader_state_t      r_state;
    loader_state_t      w_next;
    logic [BCW-1:0]     r_bit_cnt;
    logic [WCW-1:0]     r_words;
    logic [TCW-1:0]     r_to_cnt;
    logic [ANS_W-1:0]   r_result;
    logic               r_result_valid;
    logic               r_err_underrun;
    logic               r_err_timeout;

    logic w_idle_like;
    logic w_start_ok;
    logic w_active;
    logic w_prime;
    logic w_stream;
    logic w_words_left;
    logic w_accept;
    logic w_primed;
    logic w_underrun;
    logic w_bit_w;
    logic w_bit_p;
    logic w_last_bit;
    logic w_to_expired;

    assign w_idle_like  = (r_state == IDLE) || (r_state == DONE) || (r_state == ERR);
    assign w_start_ok   = i_start && w_idle_like;
    assign w_prime      = (r_state == PRIME);
    assign w_stream     = (r_state == STREAM);
    assign w_active     = w_prime || (r_state == START) || w_stream;
    assign w_words_left = (r_words < WORDS_L);
    assign w_last_bit   = (r_bit_cnt == LAST_BIT);
    assign w_to_expired = (r_to_cnt == TO_LAST);

    bnn_word_serializer u_ser (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_start_ok),
        .i_prime      (w_prime),
        .i_active     (w_active),
        .i_shift_en   (w_stream),
        .i_words_left (w_words_left),
        .i_s_data     (i_s_data),
        .i_s_valid    (i_s_valid),
        .o_s_ready    (o_s_ready),
        .o_accept     (w_accept),
        .o_primed     (w_primed),
        .o_underrun   (w_underrun),
        .o_bit_w      (w_bit_w),
        .o_bit_p      (w_bit_p)
    );

    always_comb begin
        w_next   = r_state;
        o_mode   = 1'b0;
        o_d_in_p = 1'b0;
        o_d_in_w = 1'b0;
        o_busy   = 1'b1;
        unique case (r_state)
            IDLE, DONE, ERR: begin
                o_busy = 1'b0;
                if (i_start) w_next = PRIME;
            end
            PRIME: begin
                if (w_primed) w_next = START;
            end
            START: begin
                o_mode = 1'b1;
                w_next = STREAM;
            end
            STREAM: begin
                o_mode   = 1'b1;
                o_d_in_w = w_bit_w;
                o_d_in_p = (r_bit_cnt < PIX_LIM) && w_bit_p;
                if (w_underrun)      w_next = ERR;
                else if (w_last_bit) w_next = WAIT_ANS;
            end
            WAIT_ANS: begin
                // An answer arriving on the timeout cycle still counts.
                if (i_ans_valid)       w_next = DONE;
                else if (w_to_expired) w_next = ERR;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_bit_cnt      <= '0;
            r_words        <= '0;
            r_to_cnt       <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err_underrun <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_bit_cnt      <= '0;
                r_words        <= '0;
                r_to_cnt       <= '0;
                r_result       <= '0;
                r_result_valid <= 1'b0;
                r_err_underrun <= 1'b0;
                r_err_timeout  <= 1'b0;
            end else begin
                if (w_accept) r_words <= r_words + 1'b1;
                if (w_stream) r_bit_cnt <= r_bit_cnt + 1'b1;
                if (w_underrun) r_err_underrun <= 1'b1;
                if (r_state == WAIT_ANS) begin
                    if (i_ans_valid) begin
                        r_result       <= i_ans_in;
                        r_result_valid <= 1'b1;
                    end else if (w_to_expired) begin
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_err_underrun = r_err_underrun;
    assign o_err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_bnn_stream_loader.sv
// Directed bench for bnn_stream_loader: a table of whole-load scenarios plus reset checks.
module tb_bnn_stream_loader;

    localparam int NW = 290;
    localparam int PB = 784;
    localparam int WB = 2320;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        mode;
    logic        d_in_p;
    logic        d_in_w;
    logic [3:0]  ans_in;
    logic        ans_valid;
    logic [3:0]  result;
    logic        result_valid;
    logic        busy;
    logic        err_underrun;
    logic        err_timeout;

    always #5 clk = ~clk;

    bnn_stream_loader #(
        .ANS_TIMEOUT (20)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_s_data       (s_data),
        .i_s_valid      (s_valid),
        .o_s_ready      (s_ready),
        .o_mode         (mode),
        .o_d_in_p       (d_in_p),
        .o_d_in_w       (d_in_w),
        .i_ans_in       (ans_in),
        .i_ans_valid    (ans_valid),
        .o_result       (result),
        .o_result_valid (result_valid),
        .o_busy         (busy),
        .o_err_underrun (err_underrun),
        .o_err_timeout  (err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int word_idx = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, ~b};
    endfunction

    function automatic logic exp_w_bit(input int k);
        logic [15:0] w;
        w = word_of(k / 8);
        return w[15 - (k % 8)];
    endfunction

    function automatic logic exp_p_bit(input int k);
        logic [15:0] w;
        if (k >= PB) return 1'b0;
        w = word_of(k / 8);
        return w[7 - (k % 8)];
    endfunction

    task automatic tick();
        logic fire;
        fire = s_valid && s_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (fire) word_idx++;
        s_data = word_of(word_idx);
    endtask

    typedef struct {
        int         half_rate;
        int         drop_at;
        int         start_at_bit;
        int         reset_at_bit;
        int         ans_delay;
        logic [3:0] ans;
        int         exp_prime;
        int         exp_mode;
        int         exp_wait;
        int         exp_words;
        int         exp_under;
        int         exp_tout;
        int         exp_rv;
        int         exp_res;
    } vec_t;

    typedef struct {
        int clr;
        int prime;
        int start_err;
        int w_err;
        int p_err;
        int mode_cnt;
        int wait_cnt;
        int words;
        int ready_late;
        int rv_early;
        int mode_end;
        int rst_out;
        int busy_left;
        int under;
        int tout;
        int rv;
        int res;
    } res_t;

    task automatic run_load(input vec_t v, output res_t r);
        int m;
        int wcnt;
        int dropping;
        bit dropped;
        bit seen_mode;
        bit stop;
        r = '{default: 0};
        m = 0; wcnt = 0; dropping = 0; dropped = 0; seen_mode = 0; stop = 0;
        word_idx = 0;
        s_data = word_of(0);
        s_valid = 1'b0;
        ans_valid = 1'b0;
        ans_in = v.ans;
        start = 1'b1;
        tick();
        start = 1'b0;
        r.clr = {result_valid, err_underrun, err_timeout};
        for (int c = 0; c < 4000 && busy && !stop; c++) begin
            if (mode) begin
                seen_mode = 1;
                if (m == 0) begin
                    if (d_in_p || d_in_w) r.start_err++;
                end else begin
                    if (d_in_w !== exp_w_bit(m - 1)) r.w_err++;
                    if (d_in_p !== exp_p_bit(m - 1)) r.p_err++;
                end
                m++;
                if (m == v.start_at_bit + 1) start = 1'b1;
            end else if (seen_mode) begin
                wcnt++;
                if (wcnt == v.ans_delay) ans_valid = 1'b1;
            end else begin
                r.prime++;
            end
            if (result_valid) r.rv_early++;
            if (word_idx >= NW && s_ready) r.ready_late++;
            if (v.reset_at_bit >= 0 && m == v.reset_at_bit + 1) begin
                reset = 1'b1;
                #1;
                r.rst_out = int'({s_ready, mode, d_in_p, d_in_w, result, result_valid, busy,
                                  err_underrun, err_timeout});
                stop = 1;
            end else begin
                if (v.drop_at >= 0 && !dropped && word_idx == v.drop_at) begin
                    dropping = 16;
                    dropped = 1;
                end
                s_valid = (dropping == 0) && (v.half_rate == 0 || (cyc % 2) == 0);
                if (dropping > 0) dropping--;
                tick();
                ans_valid = 1'b0;
                start = 1'b0;
            end
        end
        r.mode_end = mode;
        r.mode_cnt = m;
        r.wait_cnt = wcnt;
        r.words = word_idx;
        s_valid = 1'b0;
        if (stop) begin
            tick();
            reset = 1'b0;
        end
        for (int i = 0; i < 3; i++) tick();
        r.busy_left = busy;
        r.under = err_underrun;
        r.tout = err_timeout;
        r.rv = result_valid;
        r.res = result;
    endtask

    task automatic check_load(input int id, input vec_t v, input res_t r);
        check($sformatf("v%0d clear_on_start", id), r.clr, 0);
        if (v.exp_prime >= 0) check($sformatf("v%0d prime_cycles", id), r.prime, v.exp_prime);
        check($sformatf("v%0d start_lanes_low", id), r.start_err, 0);
        check($sformatf("v%0d weight_bit_errors", id), r.w_err, 0);
        check($sformatf("v%0d pixel_bit_errors", id), r.p_err, 0);
        check($sformatf("v%0d mode_cycles", id), r.mode_cnt, v.exp_mode);
        check($sformatf("v%0d wait_cycles", id), r.wait_cnt, v.exp_wait);
        if (v.exp_words >= 0) check($sformatf("v%0d words_accepted", id), r.words, v.exp_words);
        check($sformatf("v%0d ready_after_last_word", id), r.ready_late, 0);
        check($sformatf("v%0d result_valid_early", id), r.rv_early, 0);
        check($sformatf("v%0d mode_after_load", id), r.mode_end, 0);
        check($sformatf("v%0d outputs_in_reset", id), r.rst_out, 0);
        check($sformatf("v%0d busy_at_end", id), r.busy_left, 0);
        check($sformatf("v%0d err_underrun", id), r.under, v.exp_under);
        check($sformatf("v%0d err_timeout", id), r.tout, v.exp_tout);
        check($sformatf("v%0d result_valid", id), r.rv, v.exp_rv);
        if (v.exp_rv != 0) check($sformatf("v%0d result", id), r.res, v.exp_res);
    endtask

    vec_t vecs[6];

    initial begin
        res_t r;
        //          half drop stB  rstB dly ans    prime mode wait words und to rv res
        vecs[0] = '{0, -1,  -1,  -1,  10, 4'h7,  3, 2321, 10, 290, 0, 0, 1, 7};
        vecs[1] = '{0,  50, -1,  -1,  -1, 4'h0,  3,  401,  0,  50, 1, 0, 0, 0};
        vecs[2] = '{0, -1,  -1,  -1,  -1, 4'h5,  3, 2321, 20, 290, 0, 1, 0, 0};
        vecs[3] = '{1, -1,  -1,  -1,   3, 4'hA, -1, 2321,  3, 290, 0, 0, 1, 10};
        vecs[4] = '{0, -1,  -1, 1000, -1, 4'h9,  3, 1001,  0,  -1, 0, 0, 0, 0};
        vecs[5] = '{0, -1, 500,  -1,   1, 4'h3,  3, 2321,  1, 290, 0, 0, 1, 3};

        reset = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        ans_in = 4'hF;
        ans_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset s_ready", int'(s_ready), 0);
        check("reset mode", int'(mode), 0);
        check("reset lanes", int'({d_in_p, d_in_w}), 0);
        check("reset result", int'({result_valid, result}), 0);
        check("reset flags", int'({busy, err_underrun, err_timeout}), 0);
        reset = 1'b0;
        s_valid = 1'b1;
        tick();
        check("idle s_ready", int'(s_ready), 0);
        check("idle busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_load(vecs[i], r);
            check_load(i, vecs[i], r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
